// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with return-address stack and run/halt control
module fetch_sequencer #(
   parameter int          STACK_DEPTH = 8,
   parameter logic [13:0] NOP_WORD    = 14'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] rom_addr_out,
   input  logic [13:0] rom_data_in,
   output logic [13:0] ir_out,
   output logic        ir_valid,
   output logic [10:0] pc_out,
   input  logic        stall,
   input  logic        goto_en,
   input  logic        call_en,
   input  logic        ret_en,
   input  logic        skip_en,
   input  logic [10:0] target_addr,
   input  logic        halt_req,
   input  logic        run_req,
   output logic        halted,
   output logic [3:0]  stack_depth,
   output logic        stack_overflow,
   output logic        stack_underflow
);

   localparam int              PW   = $clog2(STACK_DEPTH);
   localparam logic [PW-1:0]   LAST = PW'(STACK_DEPTH - 1);
   localparam logic [3:0]      DMAX = 4'(STACK_DEPTH);

   typedef enum logic {RUN, HALT} state_t;

   state_t        state;
   logic [10:0]   pc;
   logic [PW-1:0] top;
   logic [10:0]   stack [STACK_DEPTH];

   logic          active;
   logic          do_ret;
   logic          do_call;
   logic          do_goto;
   logic          do_skip;
   logic          redirect;
   logic [PW-1:0] top_inc;
   logic [PW-1:0] top_dec;

   assign pc_out       = pc;
   assign rom_addr_out = pc;
   assign halted       = (state == HALT);

   always_comb begin
      active   = !stall && (state == RUN);
      do_ret   = active && ret_en;
      do_call  = active && !ret_en && call_en;
      do_goto  = active && !ret_en && !call_en && goto_en;
      do_skip  = active && !ret_en && !call_en && !goto_en && skip_en;
      redirect = do_ret || do_call || do_goto || do_skip;
      top_inc  = (top == LAST) ? '0 : top + PW'(1);
      top_dec  = (top == '0) ? LAST : top - PW'(1);
   end

   // top points at the next free slot; when full that slot holds the oldest entry
   always_ff @(posedge clk) begin
      if (do_call)
         stack[top] <= pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= RUN;
         pc              <= 11'h000;
         ir_out          <= NOP_WORD;
         ir_valid        <= 1'b0;
         top             <= '0;
         stack_depth     <= 4'd0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else if (!stall) begin
         case (state)
            RUN: begin
               if (do_ret) begin
                  if (stack_depth == 4'd0) begin
                     pc              <= 11'h000;
                     stack_underflow <= 1'b1;
                  end else begin
                     pc          <= stack[top_dec];
                     top         <= top_dec;
                     stack_depth <= stack_depth - 4'd1;
                  end
               end else if (do_call) begin
                  pc  <= target_addr;
                  top <= top_inc;
                  if (stack_depth == DMAX)
                     stack_overflow <= 1'b1;
                  else
                     stack_depth <= stack_depth + 4'd1;
               end else if (do_goto) begin
                  pc <= target_addr;
               end else if (do_skip || !halt_req) begin
                  pc <= pc + 11'd1;
               end
               // a plain halt keeps pc so the discarded word is refetched on resume
               if (redirect || halt_req) begin
                  ir_out   <= NOP_WORD;
                  ir_valid <= 1'b0;
               end else begin
                  ir_out   <= rom_data_in;
                  ir_valid <= 1'b1;
               end
               if (halt_req)
                  state <= HALT;
            end
            HALT: begin
               ir_valid <= 1'b0;
               if (run_req)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
